// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin write arbiter that lets four requesters share one simple_fifo.
// A winner keeps the grant for up to BURST words. It loses the grant early if it drops req.
// The grant is held, with no transfer, while the FIFO reports full.
// Optional macro FIFO_ARB_STATS_EN adds per-requester accepted-word counters
// that are read out through stat_sel / stat_count.
module fifo_write_arbiter #(
   parameter int WIDTH = 32,
   parameter int BURST = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         req,
   input  logic [4*WIDTH-1:0] din,
   output logic [3:0]         ack,
   output logic               fifo_we,
   output logic [WIDTH-1:0]   fifo_din,
   input  logic               fifo_full,
   output logic [1:0]         owner,
   output logic               busy
`ifdef FIFO_ARB_STATS_EN
   ,
   input  logic [1:0]         stat_sel,
   output logic [15:0]        stat_count
`endif
);

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   localparam logic [3:0] BURST_C = 4'(BURST);

   state_t           state;
   logic [1:0]       ptr;
   logic [3:0]       cnt;
   logic [1:0]       winner;
   logic [1:0]       cand;
   logic [1:0]       gnt;
   logic             gnt_vld;
   logic             xfer;
   logic [3:0]       cnt_inc;
   logic [WIDTH-1:0] din_w [4];

   for (genvar i = 0; i < 4; i++) begin : g_din
      assign din_w[i] = din[i*WIDTH +: WIDTH];
   end

   // Round-robin search from ptr+1. Walking backwards lets the nearest candidate overwrite the farther ones.
   always_comb begin
      winner = '0;
      cand   = '0;
      for (int k = 4; k >= 1; k--) begin
         cand = ptr + 2'(k);
         if (req[cand]) winner = cand;
      end
   end

   // The grant source comes from the search when IDLE and from the held owner when LOCK.
   // Reset masks any transfer, so no ack can leak out while reset is high.
   always_comb begin
      gnt      = (state == LOCK) ? owner : winner;
      gnt_vld  = (state == LOCK) ? req[owner] : |req;
      xfer     = gnt_vld & ~fifo_full & ~reset;
      fifo_we  = xfer;
      fifo_din = xfer ? din_w[gnt] : '0;
      ack      = xfer ? (4'b0001 << gnt) : 4'b0000;
   end

   assign busy    = (state == LOCK);
   assign cnt_inc = cnt + 4'd1;

   // Arbitration FSM. Owner returns to 0 whenever the grant is released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= 2'd3;
         cnt   <= '0;
         owner <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  if (BURST_C == 4'd1 && xfer) begin
                     // A single-beat burst finishes immediately, so the block never enters LOCK.
                     ptr <= winner;
                  end else begin
                     state <= LOCK;
                     owner <= winner;
                     cnt   <= xfer ? 4'd1 : 4'd0;
                  end
               end
            end
            LOCK: begin
               if (!req[owner] || (xfer && cnt_inc == BURST_C)) begin
                  state <= IDLE;
                  ptr   <= owner;
                  cnt   <= '0;
                  owner <= '0;
               end else if (xfer) begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               owner <= '0;
            end
         endcase
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] stat_q [4];

   for (genvar i = 0; i < 4; i++) begin : g_stat
      // Each counter tallies the words accepted for its requester and saturates at the top value.
      always_ff @(posedge clk or posedge reset) begin
         if (reset)                              stat_q[i] <= '0;
         else if (ack[i] && stat_q[i] != 16'hFFFF) stat_q[i] <= stat_q[i] + 16'd1;
      end
   end

   assign stat_count = stat_q[stat_sel];
`endif

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data word width in bits.
REQ-002 The block SHALL have parameter BURST, default 4, legal range 1..15: maximum words accepted per grant.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 4 bits: per-requester write request, level-held while that requester has a word to send.
REQ-006 The block SHALL have port din, input, 4*WIDTH bits: requester i data at bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port ack, output, 4 bits: one-hot pulse meaning that requester's current word is written this cycle.
REQ-008 The block SHALL have port fifo_we, output, 1 bit: write enable to the shared simple_fifo.
REQ-009 The block SHALL have port fifo_din, output, WIDTH bits: write data to the shared FIFO.
REQ-010 The block SHALL have port fifo_full, input, 1 bit: full flag from the shared FIFO.
REQ-011 The block SHALL have port owner, output, 2 bits: index of the requester currently holding the grant (0 in IDLE).
REQ-012 The block SHALL have port busy, output, 1 bit: high in state LOCK.

Function
REQ-013 The block SHALL implement two states: IDLE (no grant held) and LOCK (grant held by owner).
REQ-014 The block SHALL keep a round-robin pointer ptr (2 bits); in IDLE the winner is the first asserted req searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-015 A transfer SHALL occur in a cycle when a granted requester has req high and fifo_full is low: fifo_we=1, fifo_din=din of that requester, ack bit of that requester=1, all combinational (zero latency).
REQ-016 In IDLE with any req high, the winner SHALL be granted that same cycle; transfer per REQ-015.
REQ-017 From IDLE with a winner, the next state SHALL be LOCK with owner=winner, beat count = 1 if transferred else 0, unless BURST=1 and a transfer occurred, in which case the block stays IDLE and ptr<=winner.
REQ-018 In LOCK a transfer SHALL increment the beat count; when it reaches BURST the next state SHALL be IDLE, ptr<=owner, count<=0.
REQ-019 In LOCK with req[owner] low, no transfer SHALL occur and the next state SHALL be IDLE, ptr<=owner, count<=0.
REQ-020 In LOCK with fifo_full high, the grant SHALL be held with no transfer and no count change; other requesters SHALL NOT be granted.
REQ-021 ack, fifo_we SHALL be 0 whenever no transfer occurs; fifo_din SHALL be 0 when fifo_we is 0.
REQ-022 At most one ack bit SHALL be high in any cycle, and it SHALL equal fifo_we for that requester.

Reset
REQ-023 While reset is high: state=IDLE, ptr=3 (requester 0 wins first), count=0, owner=0, busy=0, ack=0, fifo_we=0, fifo_din=0, statistics counters=0.
REQ-024 Reset asserted mid-burst SHALL abort the grant immediately with no further ack; no partial state survives.

Configuration
REQ-025 With macro FIFO_ARB_STATS_EN defined, the block SHALL add input stat_sel (2 bits) and output stat_count (16 bits) showing the selected requester's accepted-word count, incrementing per ack and saturating at 65535.
REQ-026 Without FIFO_ARB_STATS_EN, those ports and counters SHALL be absent and behaviour otherwise identical.

Verification
REQ-027 Reset release, req=4'b1111, fifo_full=0, BURST=4 -> requester 0 acked 4 consecutive cycles, then 1 cycle IDLE-free regrant to 1 (four acks), then 2, then 3, then 0.
REQ-028 req=4'b0010 only, din[1]=32'hA5A5_0001 -> same-cycle fifo_we=1, fifo_din=32'hA5A5_0001, ack=4'b0010.
REQ-029 Owner 2 in LOCK after 2 beats, fifo_full=1 for 3 cycles with req=4'b1111 -> no fifo_we, owner stays 2; after full drops, 2 more acks to requester 2, then grant to 3.
REQ-030 Owner 0 drops req after 1 beat -> next cycle IDLE, ptr=0, requester 1 (if requesting) granted.
REQ-031 Reset pulsed during beat 3 of owner 1 -> ack/fifo_we low during reset; after release requester 0 wins first.
REQ-032 With FIFO_ARB_STATS_EN, 10 accepted words from requester 3, stat_sel=3 -> stat_count=10; other selectors unchanged.
